// File: rtl/parking_pkg.sv
// Shared types for the parking-lot occupancy tracker: one-hot lot status
// and the bit positions used for case (1'b1) decoding.
package parking_pkg;

    localparam int S_EMPTY    = 0;
    localparam int S_AVAIL    = 1;
    localparam int S_NEARFULL = 2;
    localparam int S_FULL     = 3;

    typedef enum logic [3:0] {
        EMPTY    = 4'b0001 << S_EMPTY,
        AVAIL    = 4'b0001 << S_AVAIL,
        NEARFULL = 4'b0001 << S_NEARFULL,
        FULL     = 4'b0001 << S_FULL
    } lot_status_t;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on the rising edge of a level input; a level held
// high produces exactly one pulse.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q, d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d_d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/parking_counter.sv
// Saturating car-count tracker with one-hot lot status and status flags.
// Define PARKING_COUNTER_ERR_EN to add the sticky 'error' output.
module parking_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY  = 64,
    parameter int NEAR_FULL = 56,
    parameter int CW        = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          near_full,
    output logic          full
`ifdef PARKING_COUNTER_ERR_EN
    ,
    output logic          error
`endif
);

    localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);
    localparam logic [CW-1:0] NF_C  = CW'(NEAR_FULL);

    logic inc_ev, dec_ev;

    rise_detect u_inc_rd (.clk(clk), .rst(rst), .d(inc), .pulse(inc_ev));
    rise_detect u_dec_rd (.clk(clk), .rst(rst), .d(dec), .pulse(dec_ev));

    logic [CW-1:0] count_q, count_d;
    lot_status_t   state_q, state_d;

    function automatic lot_status_t decode(input logic [CW-1:0] c);
        if (c == '0)         return EMPTY;
        else if (c == CAP_C) return FULL;
        else if (c >= NF_C)  return NEARFULL;
        else                 return AVAIL;
    endfunction

    // Bounds are checked before the add/subtract, so count never wraps.
    always_comb begin
        count_d = count_q;
        if (clear)                          count_d = '0;
        else if (inc_ev && dec_ev)          count_d = count_q;
        else if (inc_ev && count_q < CAP_C) count_d = count_q + 1'b1;
        else if (dec_ev && count_q != '0)   count_d = count_q - 1'b1;
    end

    // Status follows the next count so state and count change on the same edge.
    always_comb begin
        state_d = decode(count_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            state_q <= EMPTY;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        empty     = 1'b0;
        near_full = 1'b0;
        full      = 1'b0;
        case (1'b1)
            state_q[S_EMPTY]:    empty     = 1'b1;
            state_q[S_NEARFULL]: near_full = 1'b1;
            state_q[S_FULL]:     full      = 1'b1;
            default: ;
        endcase
    end

    assign count = count_q;

`ifdef PARKING_COUNTER_ERR_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if (clear)
            error_d = 1'b0;
        else if ((inc_ev && !dec_ev && count_q == CAP_C) ||
                 (dec_ev && !inc_ev && count_q == '0))
            error_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= error_d;
    end

    assign error = error_q;
`endif

endmodule

// File: tb/tb_parking_counter.sv
// Directed bench for parking_counter: a per-cycle vector table plus
// hand-written fill/saturate/clear/reset sequences.
module tb_parking_counter;

    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst, inc, dec, clear;
    logic [CW-1:0] count;
    logic          empty, near_full, full;
`ifdef PARKING_COUNTER_ERR_EN
    logic          error;
`endif

    int checks = 0;
    int errors = 0;

    parking_counter #(.CAPACITY(64), .NEAR_FULL(56)) dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clear(clear),
        .count(count), .empty(empty), .near_full(near_full), .full(full)
`ifdef PARKING_COUNTER_ERR_EN
        , .error(error)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic inc;
        logic dec;
        logic clr;
        int   cnt;
        logic e;
        logic nf;
        logic f;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string nm, input int c);
        chk({nm, " count"}, 32'(count), c);
        chk({nm, " empty"}, 32'(empty), 32'(c == 0));
        chk({nm, " near_full"}, 32'(near_full), 32'(c >= 56 && c < 64));
        chk({nm, " full"}, 32'(full), 32'(c == 64));
    endtask

    task automatic chk_err(input string nm, input logic e);
`ifdef PARKING_COUNTER_ERR_EN
        chk(nm, 32'(error), 32'(e));
`endif
    endtask

    initial begin
        // inc dec clr | count empty near_full full (one row per cycle)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; inc = 1'b0; dec = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 0);
        chk_err("reset error", 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            inc = tbl[i].inc; dec = tbl[i].dec; clear = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d count", i), 32'(count), tbl[i].cnt);
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].e));
            chk($sformatf("vec%0d near_full", i), 32'(near_full), 32'(tbl[i].nf));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].f));
        end
        inc = 1'b0; dec = 1'b0; clear = 1'b0;

        // level held for 10 cycles counts once
        inc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("held inc count", 32'(count), 1);
        end
        inc = 1'b0;
        tick();
        chk("held inc release", 32'(count), 1);

        for (int i = 2; i <= 10; i++) begin
            inc = 1'b1; tick(); inc = 1'b0; tick();
        end
        chk_flags("at ten", 10);

        inc = 1'b1; dec = 1'b1;
        tick();
        chk("simul count", 32'(count), 10);
        chk_err("simul error", 1'b0);
        inc = 1'b0; dec = 1'b0;
        tick();

        clear = 1'b1; tick(); clear = 1'b0;
        chk_flags("clear to fill", 0);

        for (int i = 1; i <= 64; i++) begin
            inc = 1'b1;
            tick();
            chk_flags($sformatf("fill%0d", i), i);
            inc = 1'b0;
            tick();
        end

        inc = 1'b1;
        tick();
        chk_flags("saturate", 64);
        chk_err("saturate error", 1'b1);
        inc = 1'b0;
        tick();

        for (int i = 63; i >= 40; i--) begin
            dec = 1'b1;
            tick();
            chk_flags($sformatf("drain%0d", i), i);
            dec = 1'b0;
            tick();
        end
        chk_err("error sticky", 1'b1);

        clear = 1'b1; inc = 1'b1;
        tick();
        clear = 1'b0;
        chk_flags("clear+inc", 0);
        chk_err("clear error", 1'b0);
        inc = 1'b0;
        tick();
        chk("after clear+inc", 32'(count), 0);

        dec = 1'b1;
        tick();
        chk_flags("floor", 0);
        chk_err("floor error", 1'b1);
        dec = 1'b0;
        tick();

        for (int i = 1; i <= 3; i++) begin
            inc = 1'b1; tick(); inc = 1'b0; tick();
        end
        chk("pre-reset count", 32'(count), 3);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_flags("async reset", 0);
        chk_err("async reset error", 1'b0);

        // dec held across reset release: one event, floored
        dec = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk_flags("release dec", 0);
        chk_err("release dec error", 1'b1);
        tick();
        chk("release dec held", 32'(count), 0);
        dec = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_counter.md
# parking_counter

Occupancy tracker that sits directly downstream of the parking-lot entry/exit detector. It consumes the detector's `inc`/`dec` event outputs and its `reset` request, and maintains a saturating count of cars in the lot. It also drives lot status flags (empty, available, nearly full, full) for signage and gate logic. Under a configuration macro it keeps a sticky error flag for impossible events.

## Interface
Parameters:
- `CAPACITY`, 64: maximum number of cars; must be ≥ 2.
- `NEAR_FULL`, 56: count at or above which `near_full` asserts; must satisfy 1 ≤ `NEAR_FULL` < `CAPACITY`.
- `CW`, `$clog2(CAPACITY+1)`: count width; derived, not overridden.

Ports:
- `clk`, input, 1: single clock for the whole block.
- `rst`, input, 1: asynchronous, active-high reset.
- `inc`, input, 1: entry event from the detector; level, counted on its rising edge.
- `dec`, input, 1: exit event from the detector; level, counted on its rising edge.
- `clear`, input, 1: synchronous clear, driven by the detector's `reset` output.
- `count`, output, CW: current occupancy.
- `empty`, output, 1: `count` == 0.
- `near_full`, output, 1: `count` ≥ `NEAR_FULL` and < `CAPACITY`.
- `full`, output, 1: `count` == `CAPACITY`.
- `error`, output, 1: sticky; inc-while-full or dec-while-empty seen. Present only with the macro.

## Operation
- Rising-edge qualify: `inc_ev = inc & ~inc_q`, `dec_ev = dec & ~dec_q`, where `inc_q`/`dec_q` are registered copies of the inputs.
  - A level held high counts once.
  - A one-cycle pulse counts once.
- Count update, in priority order:
  - `clear`: count ← 0. The edge-detect registers still update.
  - `inc_ev & dec_ev`: no change (net zero).
  - `inc_ev`: count+1 if count < `CAPACITY`; otherwise hold (saturate).
  - `dec_ev`: count−1 if count > 0; otherwise hold (floor).
  - None of the above: hold.
- Status FSM, one-hot, 4 states:
  - EMPTY: count == 0
  - AVAIL: 0 < count < `NEAR_FULL`
  - NEARFULL: `NEAR_FULL` ≤ count < `CAPACITY`
  - FULL: count == `CAPACITY`
- FSM next state is decoded from the next count value, so state and count always agree.
- Legal transitions are only between adjacent states, plus any state → EMPTY on `clear`.
- Flags are registered decodes of state: `empty` = EMPTY, `near_full` = NEARFULL, `full` = FULL. AVAIL asserts no flag.
- No arithmetic wrap is possible: the saturation check happens before the add/subtract, in CW bits.

## Timing
- Reset values: `count` = 0, state EMPTY, `empty` = 1, `near_full` = 0, `full` = 0, `error` = 0, `inc_q` = `dec_q` = 0.
- Latency: input rise sampled at edge N → `count` and flags updated after edge N (visible in cycle N+1).
- Minimum spacing between counted events on the same input: 2 cycles (high then low).
- Reset mid-operation clears everything immediately and asynchronously. An input held high through reset release counts once at the first edge after release, because `inc_q`/`dec_q` reset to 0.
- `clear` takes effect at the next edge and overrides a simultaneous event. Under the macro it also clears `error`.

## Configuration
- `PARKING_COUNTER_ERR_EN` defined:
  - `error` port and its logic exist.
  - `error` sets on `inc_ev` while count == `CAPACITY` without `dec_ev`.
  - `error` sets on `dec_ev` while count == 0 without `inc_ev`.
  - `error` holds until `rst` or `clear`.
- Undefined: the `error` port and its register are absent. Saturation behaviour is unchanged.

## Structure
- Package `parking_pkg` holds:
  - the `lot_status_t` one-hot enum (EMPTY, AVAIL, NEARFULL, FULL);
  - bit-index localparams for `case (1'b1)` decoding.
- Sub-module `rise_detect` (inputs `clk`, `rst`, `d`; output `pulse`) is instantiated twice, for `inc` and `dec`.
- The count register and the status FSM are in the top level.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `count` = 0 and `empty` = 1 immediately; `error` = 0.
- Fill: 64 single-cycle `inc` pulses spaced 2 cycles apart →
  - `count` steps 0→64;
  - `near_full` asserts at 56 and deasserts at 64;
  - `full` = 1 at 64, one cycle after the 64th pulse.
- Saturate and floor:
  - a 65th `inc` → `count` stays 64 and `error` = 1 (with macro);
  - from 0, a `dec` → `count` stays 0.
- Held level and simultaneity:
  - `inc` held high for 10 cycles → `count` increases by exactly 1;
  - `inc` and `dec` rising on the same cycle at count 10 → `count` stays 10, no error.
- Clear: at count 40 with `error` = 1, pulse `clear` together with an `inc` rise → `count` = 0, EMPTY, `error` = 0 next cycle.
- Reset release with `dec` held high at count 0 → no underflow; `count` stays 0 and `error` sets once (with macro).
